// File: rtl/if_stage_pkg.sv
// Shared pipeline package: NOP encoding, fetch FSM state type and the
// default reset PC used by the instruction fetch stage.
package if_stage_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // REQ   : request presented to instruction memory, waiting for grant
  // WAIT  : request granted, waiting for read data
  // FULL  : data arrived while decode was stalled, held in the buffer
  // DRAIN : response still owed for a fetch killed by a redirect
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
//   flush   : redirect; drop contents (valid=0, inst=NOP, pc kept)
//   load    : capture a delivered instruction and its PC
//   hold    : decode stall; keep everything
//   none    : bubble (valid=0, inst=NOP, pc kept)
// Priority: flush > load > hold > bubble.
module ifid_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] inst_d,
  input  logic [31:0] pc_d,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o  <= NOP;
      pc_o    <= '0;
      valid_o <= 1'b0;
    end else if (flush) begin
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end else if (load) begin
      inst_o  <= inst_d;
      pc_o    <= pc_d;
      valid_o <= 1'b1;
    end else if (!hold) begin
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with a single outstanding memory request.
//   clk, rst                     : clock, async active-high reset
//   imem_req_o / imem_addr_o     : fetch request and word-aligned address
//   imem_gnt_i                   : memory accepted the request
//   imem_rvalid_i / imem_rdata_i : read response
//   stall_i                      : decode hold
//   redirect_i / redirect_pc_i   : taken branch/jump, flush and refetch
//   inst_o / pc_o / valid_o      : IF/ID register contents
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  buffer_q;
  logic         load;
  logic [31:0]  load_inst;

  // Target is forced word-aligned; the low bits are intentionally dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;

  always_comb begin
    load      = 1'b0;
    load_inst = imem_rdata_i;
    if (!redirect_i && !stall_i) begin
      case (state_q)
        S_WAIT: load = imem_rvalid_i;
        S_FULL: begin
          load      = 1'b1;
          load_inst = buffer_q;
        end
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      buffer_q   <= NOP;
    end else if (redirect_i) begin
      pc_q <= {redirect_pc_i[31:2], 2'b00};
      // A request already granted still owes a response; drain it.
      case (state_q)
        S_REQ:   state_q <= imem_gnt_i    ? S_DRAIN : S_REQ;
        S_WAIT:  state_q <= imem_rvalid_i ? S_REQ   : S_DRAIN;
        S_FULL:  state_q <= S_REQ;
        S_DRAIN: state_q <= imem_rvalid_i ? S_REQ   : S_DRAIN;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt_i) begin
            fetch_pc_q <= pc_q;
            pc_q       <= pc_q + 32'd4;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (stall_i) begin
              buffer_q <= imem_rdata_i;
              state_q  <= S_FULL;
            end else begin
              state_q  <= S_REQ;
            end
          end
        end
        S_FULL: begin
          if (!stall_i) state_q <= S_REQ;
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_i),
    .load    (load),
    .hold    (stall_i),
    .inst_d  (load_inst),
    .pc_d    (fetch_pc_q),
    .inst_o  (inst_o),
    .pc_o    (pc_o),
    .valid_o (valid_o)
  );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_o  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr_o  output  32  fetch address, word-aligned.
REQ-006 SHALL have port imem_gnt_i  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_rvalid_i  input  1  read data valid.
REQ-008 SHALL have port imem_rdata_i  input  32  fetched instruction.
REQ-009 SHALL have port stall_i  input  1  ID stage hold (hazard).
REQ-010 SHALL have port redirect_i  input  1  branch/jal taken; flush and refetch.
REQ-011 SHALL have port redirect_pc_i  input  32  target PC.
REQ-012 SHALL have port inst_o  output  32  IF/ID instruction, feeds decode and immediate generation.
REQ-013 SHALL have port pc_o  output  32  IF/ID PC.
REQ-014 SHALL have port valid_o  output  1  IF/ID contents valid.

Function
REQ-015 SHALL keep at most one memory request outstanding.
REQ-016 SHALL implement FSM states REQ, WAIT, FULL, DRAIN; imem_req_o=1 only in REQ; imem_addr_o=pc_q always.
REQ-017 REQ: gnt -> fetch_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, FFFF_FFFC wraps to 0), go WAIT; no gnt -> stay.
REQ-018 WAIT: rvalid & !stall_i -> IF/ID loads {rdata, fetch_pc_q, valid=1}, go REQ; rvalid & stall_i -> buffer<=rdata, go FULL; no rvalid -> stay.
REQ-019 FULL: !stall_i -> IF/ID loads {buffer, fetch_pc_q, 1}, go REQ; stall_i -> stay, no request.
REQ-020 DRAIN: rvalid -> discard data, go REQ; no rvalid -> stay.
REQ-021 redirect_i SHALL have priority over stall_i and all transitions: pc_q<={redirect_pc_i[31:2],2'b00}; valid_o<=0, inst_o<=NOP (32'h0000_0013) same edge.
REQ-022 Redirect state effects: REQ&gnt -> DRAIN; REQ&!gnt -> REQ; WAIT&!rvalid -> DRAIN; WAIT&rvalid -> REQ (data dropped); FULL -> REQ (buffer dropped); DRAIN&rvalid -> REQ; DRAIN&!rvalid -> DRAIN.
REQ-023 stall_i=1, no redirect: IF/ID register SHALL hold inst_o, pc_o, valid_o.
REQ-024 stall_i=0, no redirect, no delivery: valid_o<=0, inst_o<=NOP, pc_o unchanged.
REQ-025 Latency: gnt at edge N, rvalid in cycle N+1 -> inst_o valid after edge N+1; peak throughput one instruction per two cycles.

Reset
REQ-026 rst SHALL asynchronously set pc_q=RESET_PC, fetch_pc_q=0, buffer=NOP, state=REQ, inst_o=NOP, pc_o=0, valid_o=0.
REQ-027 Reset mid-transaction SHALL abandon outstanding request; memory responses arriving in REQ SHALL be ignored.

Structure
REQ-028 NOP constant, FSM state enum and RESET_PC default SHALL live in the shared pipeline package.
REQ-029 IF/ID output register (load/hold/flush) SHALL be sub-module ifid_reg; FSM and PC logic stay in if_stage.

Verification
REQ-030 Reset, gnt=1 always, rvalid one cycle after gnt, rdata=00500093 -> imem_addr_o 0,4,8; inst_o=00500093, pc_o=0, valid_o=1 two cycles after reset release.
REQ-031 stall_i=1 while rvalid returns pc 8 data -> FSM FULL, imem_req_o=0, outputs hold; stall_i=0 -> inst_o=buffered word, pc_o=8.
REQ-032 redirect_i=1, redirect_pc_i=0x103 while WAIT, rvalid 2 cycles later -> DRAIN, that data never on inst_o; next imem_addr_o=0x100.
REQ-033 redirect_i and stall_i simultaneous in FULL -> valid_o=0, inst_o=NOP, next request address=redirect target.
REQ-034 RESET_PC=FFFF_FFFC -> second request address 0x0000_0000.
REQ-035 rst asserted in WAIT -> outputs at reset values immediately (no clock edge), first request at RESET_PC after release.
